// File: rtl/branch_resolve_unit.sv
// Branch resolution: carries gshare metadata ID->EX->MEM, evaluates the
// condition in EX and emits the predictor update, flush and redirect in MEM.
module branch_resolve_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic        id_pred_taken,
    input  logic [2:0]  id_pht_index,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic [2:0]  id_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    output logic        branch_resolved,
    output logic        actual_taken,
    output logic [2:0]  pht_indexMEM,
    output logic        mispredict,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic        ex_valid_q, ex_valid_d;
    logic        ex_pred_q, ex_pred_d;
    logic [2:0]  ex_pht_q, ex_pht_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_target_q, ex_target_d;
    logic [2:0]  ex_funct3_q, ex_funct3_d;

    logic        mem_valid_q, mem_valid_d;
    logic        mem_pred_q, mem_pred_d;
    logic [2:0]  mem_pht_q, mem_pht_d;
    logic [31:0] mem_pc_q, mem_pc_d;
    logic [31:0] mem_target_q, mem_target_d;
    logic        mem_taken_q, mem_taken_d;
    logic        mem_done_q, mem_done_d;

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic        ex_taken;

    always_comb begin
        ex_taken = 1'b0;
        case (ex_funct3_q)
            3'b000:  ex_taken = (ex_rs1 == ex_rs2);
            3'b001:  ex_taken = (ex_rs1 != ex_rs2);
            3'b100:  ex_taken = ($signed(ex_rs1) < $signed(ex_rs2));
            3'b101:  ex_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  ex_taken = (ex_rs1 < ex_rs2);
            3'b111:  ex_taken = (ex_rs1 >= ex_rs2);
            default: ex_taken = 1'b0;
        endcase
    end

    assign branch_resolved  = mem_valid_q & ~mem_done_q;
    assign actual_taken     = mem_taken_q;
    assign pht_indexMEM     = mem_pht_q;
    assign mispredict       = branch_resolved & (mem_pred_q != mem_taken_q);
    assign flush            = mispredict;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    // Gated to zero so the fetch mux sees a clean value when not redirecting.
    always_comb begin
        redirect_pc = 32'h0;
        if (branch_resolved)
            redirect_pc = mem_taken_q ? mem_target_q : mem_pc_q + 32'd4;
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pred_d    = ex_pred_q;
        ex_pht_d     = ex_pht_q;
        ex_pc_d      = ex_pc_q;
        ex_target_d  = ex_target_q;
        ex_funct3_d  = ex_funct3_q;
        mem_valid_d  = mem_valid_q;
        mem_pred_d   = mem_pred_q;
        mem_pht_d    = mem_pht_q;
        mem_pc_d     = mem_pc_q;
        mem_target_d = mem_target_q;
        mem_taken_d  = mem_taken_q;
        mem_done_d   = mem_done_q;

        if (!stall) begin
            ex_valid_d   = id_valid & id_is_branch;
            ex_pred_d    = id_pred_taken;
            ex_pht_d     = id_pht_index;
            ex_pc_d      = id_pc;
            ex_target_d  = id_target;
            ex_funct3_d  = id_funct3;
            mem_valid_d  = ex_valid_q;
            mem_pred_d   = ex_pred_q;
            mem_pht_d    = ex_pht_q;
            mem_pc_d     = ex_pc_q;
            mem_target_d = ex_target_q;
            mem_taken_d  = ex_taken;
            mem_done_d   = 1'b0;
        end else if (branch_resolved) begin
            mem_done_d = 1'b1;
        end

        // Flush wins over stall; only the valid bits need clearing.
        if (flush) begin
            ex_valid_d  = 1'b0;
            mem_valid_d = 1'b0;
            mem_done_d  = 1'b0;
        end

        branch_count_d = branch_count_q;
        if (branch_resolved && branch_count_q != 32'hFFFF_FFFF)
            branch_count_d = branch_count_q + 32'd1;

        mispredict_count_d = mispredict_count_q;
        if (mispredict && mispredict_count_q != 32'hFFFF_FFFF)
            mispredict_count_d = mispredict_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q         <= 1'b0;
            ex_pred_q          <= 1'b0;
            ex_pht_q           <= 3'd0;
            ex_pc_q            <= 32'h0;
            ex_target_q        <= 32'h0;
            ex_funct3_q        <= 3'd0;
            mem_valid_q        <= 1'b0;
            mem_pred_q         <= 1'b0;
            mem_pht_q          <= 3'd0;
            mem_pc_q           <= 32'h0;
            mem_target_q       <= 32'h0;
            mem_taken_q        <= 1'b0;
            mem_done_q         <= 1'b0;
            branch_count_q     <= 32'h0;
            mispredict_count_q <= 32'h0;
        end else begin
            ex_valid_q         <= ex_valid_d;
            ex_pred_q          <= ex_pred_d;
            ex_pht_q           <= ex_pht_d;
            ex_pc_q            <= ex_pc_d;
            ex_target_q        <= ex_target_d;
            ex_funct3_q        <= ex_funct3_d;
            mem_valid_q        <= mem_valid_d;
            mem_pred_q         <= mem_pred_d;
            mem_pht_q          <= mem_pht_d;
            mem_pc_q           <= mem_pc_d;
            mem_target_q       <= mem_target_d;
            mem_taken_q        <= mem_taken_d;
            mem_done_q         <= mem_done_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: resolution, stall, flush,
// reset mid-pipeline, PC wrap and non-branch filtering.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_pred_taken;
    logic [2:0]  id_pht_index;
    logic [31:0] id_pc;
    logic [31:0] id_target;
    logic [2:0]  id_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        branch_resolved;
    logic        actual_taken;
    logic [2:0]  pht_indexMEM;
    logic        mispredict;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_pred_taken    (id_pred_taken),
        .id_pht_index     (id_pht_index),
        .id_pc            (id_pc),
        .id_target        (id_target),
        .id_funct3        (id_funct3),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .branch_resolved  (branch_resolved),
        .actual_taken     (actual_taken),
        .pht_indexMEM     (pht_indexMEM),
        .mispredict       (mispredict),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic id_br(input logic pred, input logic [2:0] pht,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [2:0] f3);
        id_valid      = 1'b1;
        id_is_branch  = 1'b1;
        id_pred_taken = pred;
        id_pht_index  = pht;
        id_pc         = pc;
        id_target     = tgt;
        id_funct3     = f3;
    endtask

    task automatic id_none();
        id_valid     = 1'b0;
        id_is_branch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        id_none();
        id_pred_taken = 1'b0; id_pht_index = 3'd0;
        id_pc = 32'h0; id_target = 32'h0; id_funct3 = 3'd0;
        ex_rs1 = 32'h0; ex_rs2 = 32'h0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_resolved", {31'd0, branch_resolved}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_taken", {31'd0, actual_taken}, 32'd0);
        chk("rst_pht", {29'd0, pht_indexMEM}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_bcount", branch_count, 32'd0);
        chk("rst_mcount", mispredict_count, 32'd0);

        // BEQ taken, predicted not-taken
        id_br(1'b0, 3'd3, 32'h100, 32'h140, 3'b000);
        tick();
        id_none(); ex_rs1 = 32'd5; ex_rs2 = 32'd5;
        tick();
        chk("beq_resolved", {31'd0, branch_resolved}, 32'd1);
        chk("beq_taken", {31'd0, actual_taken}, 32'd1);
        chk("beq_pht", {29'd0, pht_indexMEM}, 32'd3);
        chk("beq_flush", {31'd0, flush}, 32'd1);
        chk("beq_redirect", redirect_pc, 32'h140);
        tick();
        chk("beq_after", {31'd0, branch_resolved}, 32'd0);
        chk("beq_mcount", mispredict_count, 32'd1);
        chk("beq_bcount", branch_count, 32'd1);

        // BLT 1 vs -1: not taken, correct prediction
        id_br(1'b0, 3'd5, 32'h200, 32'h280, 3'b100);
        tick();
        id_none(); ex_rs1 = 32'h1; ex_rs2 = 32'hFFFF_FFFF;
        tick();
        chk("blt_resolved", {31'd0, branch_resolved}, 32'd1);
        chk("blt_taken", {31'd0, actual_taken}, 32'd0);
        chk("blt_flush", {31'd0, flush}, 32'd0);
        chk("blt_redirect", redirect_pc, 32'h204);
        tick();
        chk("blt_bcount", branch_count, 32'd2);
        chk("blt_mcount", mispredict_count, 32'd1);

        // BLTU same operands: taken, mispredicted
        id_br(1'b0, 3'd6, 32'h200, 32'h280, 3'b110);
        tick();
        id_none();
        tick();
        chk("bltu_taken", {31'd0, actual_taken}, 32'd1);
        chk("bltu_flush", {31'd0, flush}, 32'd1);
        chk("bltu_redirect", redirect_pc, 32'h280);
        tick();
        chk("bltu_mcount", mispredict_count, 32'd2);

        // BNE taken, predicted taken, then held in MEM for 4 cycles
        id_br(1'b1, 3'd1, 32'h300, 32'h340, 3'b001);
        tick();
        id_none(); ex_rs1 = 32'd1; ex_rs2 = 32'd2;
        tick();
        stall = 1'b1;
        chk("stall_first", {31'd0, branch_resolved}, 32'd1);
        chk("stall_noflush", {31'd0, flush}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {31'd0, branch_resolved}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_release", {31'd0, branch_resolved}, 32'd0);
        chk("stall_bcount", branch_count, 32'd4);
        chk("stall_mcount", mispredict_count, 32'd2);

        // Older mispredict kills the younger branch and one in ID
        id_br(1'b0, 3'd2, 32'h400, 32'h440, 3'b000);
        tick();
        id_br(1'b0, 3'd4, 32'h404, 32'h500, 3'b000);
        ex_rs1 = 32'd7; ex_rs2 = 32'd7;
        tick();
        id_br(1'b0, 3'd7, 32'h408, 32'h600, 3'b000);
        chk("kill_older_flush", {31'd0, flush}, 32'd1);
        chk("kill_older_redir", redirect_pc, 32'h440);
        tick();
        id_none();
        chk("kill_young1", {31'd0, branch_resolved}, 32'd0);
        tick();
        chk("kill_young2", {31'd0, branch_resolved}, 32'd0);
        chk("kill_bcount", branch_count, 32'd5);
        chk("kill_mcount", mispredict_count, 32'd3);

        // Reset while a branch is in EX
        id_br(1'b0, 3'd6, 32'h700, 32'h740, 3'b000);
        tick();
        id_none(); ex_rs1 = 32'd9; ex_rs2 = 32'd9;
        rst = 1'b1;
        tick();
        chk("rmid_resolved", {31'd0, branch_resolved}, 32'd0);
        chk("rmid_pht", {29'd0, pht_indexMEM}, 32'd0);
        chk("rmid_redirect", redirect_pc, 32'h0);
        chk("rmid_bcount", branch_count, 32'd0);
        rst = 1'b0;
        tick();
        chk("rmid_after", {31'd0, branch_resolved}, 32'd0);
        chk("rmid_mcount", mispredict_count, 32'd0);

        // PC wrap: not taken at 0xFFFFFFFC, predicted taken
        id_br(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h10, 3'b000);
        tick();
        id_none(); ex_rs1 = 32'd1; ex_rs2 = 32'd2;
        tick();
        chk("wrap_flush", {31'd0, flush}, 32'd1);
        chk("wrap_taken", {31'd0, actual_taken}, 32'd0);
        chk("wrap_redirect", redirect_pc, 32'h0);
        tick();
        chk("wrap_bcount", branch_count, 32'd1);

        // JAL in ID is not a conditional branch
        id_valid = 1'b1; id_is_branch = 1'b0; id_pred_taken = 1'b1;
        tick();
        id_none();
        tick();
        chk("jal_resolved", {31'd0, branch_resolved}, 32'd0);
        tick();
        chk("jal_bcount", branch_count, 32'd1);
        chk("jal_mcount", mispredict_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Carries each branch's gshare prediction metadata (predicted direction, PHT index, PC, target) from ID through EX to MEM. In EX it evaluates the real branch condition. In MEM it emits the one-cycle predictor-update pulse (`branch_resolved`, `actual_taken`, `pht_indexMEM`) consumed by `jump_branch_unit`, plus the mispredict flush and corrected fetch PC. It sits directly downstream of `jump_branch_unit` and closes the prediction loop.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold ID/EX and EX/MEM registers.
- `id_valid`  in  1  ID holds a real instruction.
- `id_is_branch`  in  1  ID instruction is a conditional branch.
- `id_pred_taken`  in  1  predicted direction from `jump_branch_unit` (`jump_taken` qualified by branch).
- `id_pht_index`  in  3  PHT index used for the prediction.
- `id_pc`  in  32  branch PC (`PC_saved`).
- `id_target`  in  32  taken target (`immID`).
- `id_funct3`  in  3  branch type.
- `ex_rs1`, `ex_rs2`  in  32  forwarded operands, valid in EX.
- `branch_resolved`  out  1  one-cycle predictor-update strobe.
- `actual_taken`  out  1  resolved direction.
- `pht_indexMEM`  out  3  PHT index of the resolving branch.
- `mispredict`  out  1  prediction was wrong.
- `flush`  out  1  squash younger stages; equals `mispredict`.
- `redirect_pc`  out  32  corrected fetch PC, valid when `flush`=1.
- `branch_count`  out  32  resolved-branch counter.
- `mispredict_count`  out  32  mispredict counter.

## Operation
- **ID/EX register.** Latches `{valid=id_valid&id_is_branch, pred, pht_index, pc, target, funct3}` when `!stall`.
- **EX compare.** Evaluated from `ex_rs1`/`ex_rs2`:
  - 000 BEQ: equal.
  - 001 BNE: not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010/011: not taken.
- **EX/MEM register.** Latches `{valid, pred, pht_index, pc, target, taken}` when `!stall`.
- **MEM outputs.** Combinational from EX/MEM plus the done flag:
  - `branch_resolved` = `mem_valid & !mem_done`.
  - `actual_taken` = `mem_taken`.
  - `pht_indexMEM` = `mem_pht_index`.
  - `mispredict` = `branch_resolved & (mem_pred != mem_taken)`.
  - `redirect_pc` = `mem_taken ? mem_target : mem_pc + 4`, modulo 2^32.
- **`mem_done` flag.**
  - Set at the posedge after `branch_resolved` if `stall`=1 (MEM held).
  - Cleared when EX/MEM advances.
  - Guarantees exactly one update pulse per branch regardless of stall length.
- **Flush.**
  - When `flush`=1, the next posedge clears ID/EX and EX/MEM valid bits.
  - Flush takes priority over `stall`.
  - Non-valid fields may keep stale data.
- **Counters.**
  - `branch_count` increments on `branch_resolved`.
  - `mispredict_count` increments on `mispredict`.
  - Both saturate at 0xFFFFFFFF.
- **Out of scope.** Unconditional jumps (`jump_early`) never enter this block: `id_is_branch`=0 means valid=0. JALR is not handled here.

## Timing
- **Reset.** All valid bits, `mem_done`, and counters are 0. All outputs are 0, including `redirect_pc` (=32'h0 when not flushing after reset, because `redirect_pc` is gated to 0 when `!branch_resolved`).
- **Latency.** A branch in ID at cycle N, with no stall, gives `branch_resolved` and `flush` in cycle N+2. The PHT/GHR update lands at the N+3 edge.
- **Stall.** Registers hold while `stall`=1. `branch_resolved` pulses only in the first cycle the branch is in MEM.
- **Flush with ID.** A flush in the same cycle as a new ID branch: that ID branch is squashed and never resolves.
- **Back-to-back branches.** These resolve in consecutive cycles, one strobe each. The older branch's flush kills the younger if the older mispredicted.
- **Reset mid-pipeline.** Reset drops all in-flight branches. No strobe is emitted in the reset cycle or the cycle after.

## Test plan
- **BEQ taken, mispredicted.** BEQ at PC 0x100, target 0x140, rs1=rs2=5, pred=0, pht=3 -> two cycles later `branch_resolved`=1, `actual_taken`=1, `pht_indexMEM`=3, `flush`=1, `redirect_pc`=0x140, `mispredict_count`=1.
- **BLT not taken, correct prediction.** BLT rs1=0x00000001, rs2=0xFFFFFFFF, pred=0 -> `actual_taken`=0 (signed 1 > -1), `flush`=0. The same operands with BLTU -> taken, mispredict, `redirect_pc`=target.
- **Stall in MEM.** Stall asserted for 4 cycles while a branch sits in MEM -> `branch_resolved` high exactly 1 cycle; `branch_count` +1.
- **Older flush kills younger.** Two consecutive branches, the first mispredicted -> the second never strobes; `branch_count`=1.
- **Reset and wrap-around.** Reset asserted while a branch is in EX -> no strobe afterwards; all outputs 0. Branch at PC 0xFFFFFFFC not taken, pred=1 -> `redirect_pc`=0x00000000.
- **Non-branch filtering.** `id_valid`=1, `id_is_branch`=0 (JAL) -> no strobe, counters unchanged.
